// File: rtl/fnd_scan_ctrl.sv
// 4-digit 7-seg scan controller with iterative binary-to-BCD conversion.
// Define FND_LEADING_BLANK_EN to blank leading zero digits (code 4'hF).
module fnd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_digitsel,
  output logic [3:0]  o_bcd
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;

  logic          wrap;
  logic          load_ok;
  logic [13:0]   sat;
  logic [15:0]   adj;
  logic [15:0]   shifted;
  logic [3:0]    dig;

  assign wrap    = (presc_q == PMAX);
  assign load_ok = i_load && (state_q != S_CONV);
  assign sat     = (i_value > 14'd9999) ? 14'd9999 : i_value;

  always_comb begin
    presc_d = wrap ? '0 : presc_q + 1'b1;
    sel_d   = wrap ? sel_q + 2'd1 : sel_q;
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in next bit
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[14:0], bin_q[13]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    unique case (1'b1)
      (state_q == S_IDLE),
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        if (load_ok) begin
          state_d = S_CONV;
          bin_d   = sat;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      (state_q == S_CONV): begin
        bin_d = {bin_q[12:0], 1'b0};
        acc_d = shifted;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = S_DONE;
          disp_d  = shifted;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      sel_q   <= '0;
      state_q <= S_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  assign o_busy     = (state_q == S_CONV);
  assign o_done     = (state_q == S_DONE);
  assign o_digitsel = sel_q;
  assign dig        = disp_q[{sel_q, 2'b00} +: 4];

`ifdef FND_LEADING_BLANK_EN
  logic [3:0] blank;
  always_comb begin
    blank[3] = (disp_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
    blank[0] = 1'b0;
  end
  assign o_bcd = blank[sel_q] ? 4'hF : dig;
`else
  assign o_bcd = dig;
`endif

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with REFRESH_DIV=4.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] i_value = '0;
  logic        i_load = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_digitsel;
  logic [3:0]  o_bcd;

  fnd_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_value    (i_value),
    .i_load     (i_load),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_digitsel (o_digitsel),
    .o_bcd      (o_bcd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit armed = 1'b0;
  bit rst_at_edge = 1'b1;
  int m_cnt = 0;
  logic [15:0] exp_disp = '0;
  logic [15:0] q_bcd[$];
  int q_due[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_dig(input logic [15:0] d,
                                         input int s);
    logic [3:0] v;
    v = d[4*s +: 4];
`ifdef FND_LEADING_BLANK_EN
    if (s == 3 && d[15:12] == 0) v = 4'hF;
    if (s == 2 && d[15:8] == 0) v = 4'hF;
    if (s == 1 && d[15:4] == 0) v = 4'hF;
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = !reset_n;
    if (!reset_n) armed = 1'b1;
  end

  // Monitor: model scan position and display, pop on completion
  always @(negedge clk) begin
    if (armed) begin
      bit ed, eb;
      int es;
      if (rst_at_edge) begin
        m_cnt = 0;
        exp_disp = '0;
        q_bcd.delete();
        q_due.delete();
      end else begin
        m_cnt++;
      end
      ed = (q_due.size() > 0) && (q_due[0] == cyc);
      chk("done", int'(o_done), int'(ed));
      if (ed) begin
        exp_disp = q_bcd.pop_front();
        void'(q_due.pop_front());
      end
      eb = (q_due.size() > 0) && (q_due[0] - cyc >= 1)
           && (q_due[0] - cyc <= 14);
      chk("busy", int'(o_busy), int'(eb));
      es = (m_cnt / 4) % 4;
      chk("digitsel", int'(o_digitsel), es);
      chk("bcd", int'(o_bcd), int'(exp_dig(exp_disp, es)));
    end
  end

  task automatic load(input logic [13:0] v, input logic [15:0] e,
                      input bit acc);
    @(negedge clk);
    i_value = v;
    i_load = 1'b1;
    if (acc) begin
      q_bcd.push_back(e);
      q_due.push_back(cyc + 15);
    end
    @(negedge clk);
    i_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(21);

    load(14'd1234, 16'h1234, 1'b1);
    idle(34);

    load(14'd16383, 16'h9999, 1'b1);
    idle(34);
    load(14'd0, 16'h0000, 1'b1);
    idle(34);

    load(14'd42, 16'h0042, 1'b1);
    idle(3);
    load(14'd7, 16'h0007, 1'b0);
    idle(34);

    load(14'd5678, 16'h5678, 1'b1);
    idle(6);
    @(negedge clk);
    reset_n = 1'b0;
    i_value = 14'd1234;
    i_load = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    i_load = 1'b0;
    idle(21);
    load(14'd9, 16'h0009, 1'b1);
    idle(34);

    load(14'd100, 16'h0100, 1'b1);
    idle(13);
    load(14'd250, 16'h0250, 1'b1);
    idle(40);

    chk("queue_drained", q_due.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cyc %0d: got running expected finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100_000: clk cycles per digit step (1 kHz at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port i_value, input, 14: binary value to display.
REQ-005 SHALL have port i_load, input, 1: single-cycle strobe requesting conversion of i_value.
REQ-006 SHALL have port o_busy, input-independent output, 1: conversion in progress.
REQ-007 SHALL have port o_done, output, 1: one-cycle pulse when display register updates.
REQ-008 SHALL have port o_digitsel, output, 2: digit index for the downstream anode decoder (0 = ones, 3 = thousands).
REQ-009 SHALL have port o_bcd, output, 4: BCD code of the digit selected by o_digitsel.

Function
REQ-010 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; o_digitsel SHALL increment by 1 in the cycle after the prescaler reaches REFRESH_DIV-1.
REQ-011 o_digitsel SHALL wrap 3 -> 0; scanning SHALL run continuously, independent of conversion state.
REQ-012 i_load sampled high while o_busy=0 SHALL capture i_value; values > 9999 SHALL saturate to 9999 at capture.
REQ-013 Conversion SHALL be iterative shift-add-3 (double dabble), one bit per cycle, 14 cycles.
REQ-014 States: IDLE, CONV, DONE. IDLE -> CONV on accepted load; CONV -> DONE after 14th shift; DONE -> IDLE unconditionally after one cycle.
REQ-015 Load accepted at edge k: o_busy SHALL be 1 for cycles k+1..k+14, o_done=1 and o_busy=0 in cycle k+15.
REQ-016 The 16-bit display register SHALL update atomically at entry to DONE; partial results SHALL never reach o_bcd.
REQ-017 i_load while o_busy=1 SHALL be ignored (no queueing, no restart).
REQ-018 i_load in the DONE cycle SHALL be accepted (o_busy=0 there); next CONV starts the following cycle.
REQ-019 o_bcd SHALL be a combinational mux of the display register indexed by registered o_digitsel; o_bcd and o_digitsel SHALL always refer to the same digit in the same cycle.
REQ-020 o_bcd SHALL hold values 0-9 only, except as allowed by REQ-025.

Reset
REQ-021 reset_n=0 at a clock edge SHALL set: prescaler 0, o_digitsel 0, display register 0000, state IDLE, o_busy 0, o_done 0; hence o_bcd 0.
REQ-022 Reset during CONV SHALL abort conversion; no o_done pulse and no display update SHALL follow.
REQ-023 i_load sampled in the same cycle as reset_n=0 SHALL be ignored.

Configuration
REQ-024 Macro FND_LEADING_BLANK_EN SHALL control leading-zero blanking.
REQ-025 With FND_LEADING_BLANK_EN defined: a digit that is zero and has only zero digits above it SHALL output o_bcd=4'hF (blank code); digit 0 SHALL never be blanked.
REQ-026 Without FND_LEADING_BLANK_EN: o_bcd SHALL always output the BCD digit, zeros included; blanking logic SHALL not be synthesized.

Verification (REFRESH_DIV=4)
REQ-027 Reset release, no load -> o_digitsel steps 0,1,2,3,0 every 4 cycles; o_bcd=0 throughout; o_busy=o_done=0.
REQ-028 Load i_value=1234 -> o_busy high 14 cycles, o_done pulse cycle 15; o_bcd = 4,3,2,1 for o_digitsel 0,1,2,3.
REQ-029 Load 16383 -> display 9999; load 0 -> display 0000 (with FND_LEADING_BLANK_EN: F,F,F,0 for digitsel 3..0 -> o_bcd 0,F,F,F for digitsel 0..3).
REQ-030 Load 42, second load 7 at busy cycle 5 -> second ignored; display 0042; exactly one o_done pulse.
REQ-031 Load 5678 then reset_n=0 at busy cycle 8 -> no o_done, display 0000, o_digitsel 0; subsequent load 9 -> display 0009 (blank build: F,F,F,9 for digitsel 3..0).
REQ-032 Load 100 then load 250 in DONE cycle -> display 0100 after first o_done, 0250 15 cycles later.
